countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, setting the counter, preset and reload width.
REQ-002 SHALL have clk  input  1  sole clock; all state changes on its rising edge except reset.
REQ-003 SHALL have reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have load  input  1  synchronous load of preset into count and reload register.
REQ-005 SHALL have preset  input  WIDTH  value captured on load.
REQ-006 SHALL have start  input  1  begin or restart a countdown.
REQ-007 SHALL have stop  input  1  abort the countdown and hold the count.
REQ-008 SHALL have count_en  input  1  decrement qualifier while running.
REQ-009 SHALL have auto_reload  input  1  periodic mode select, sampled at each terminal count.
REQ-010 SHALL have out  output  WIDTH  current count, registered.
REQ-011 SHALL have busy  output  1  high exactly while the state is RUN.
REQ-012 SHALL have tc  output  1  one-cycle terminal-count pulse, registered.
REQ-013 SHALL have done  output  1  sticky completion flag.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE, plus an internal WIDTH-bit reload register rld.
REQ-015 Event priority per edge SHALL be load > stop > start > count.
REQ-016 load: out<=preset, rld<=preset, state<=IDLE, done<=0, tc<=0, from any state.
REQ-017 stop (no load): state<=IDLE, out held, done<=0, tc<=0; stop in IDLE or DONE only clears done.
REQ-018 start in IDLE or DONE: out<=rld; next state RUN if rld!=0; if rld==0, next state DONE, done<=1 and tc<=1 for one cycle.
REQ-019 start in RUN SHALL be ignored (no restart, no count effect beyond REQ-020).
REQ-020 RUN with count_en=1 and out>1: out<=out-1; count_en=0: out held.
REQ-021 RUN with count_en=1 and out==1, auto_reload=0: out<=0, state<=DONE, done<=1, tc<=1 next cycle.
REQ-022 RUN with count_en=1 and out==1, auto_reload=1: out<=rld, tc<=1, state stays RUN, done unchanged (rld!=0 guaranteed by REQ-018).
REQ-023 tc SHALL be high for exactly one cycle per terminal count, including back-to-back periods with rld==1 (tc high every cycle).
REQ-024 out SHALL never wrap below 0 and never increment; no state other than load/start/reload writes out upward.
REQ-025 Period from start to first tc with count_en held high SHALL be rld+1 cycles (one cycle to load, rld decrements).
REQ-026 done SHALL remain high in DONE until load, stop or start.
REQ-027 busy SHALL be a function of state only (no combinational path from inputs).

Reset
REQ-028 reset low SHALL immediately force out=0, rld=0, state=IDLE, busy=0, tc=0, done=0, regardless of clk.
REQ-029 reset asserted mid-RUN SHALL abort without tc or done; after release the block SHALL sit in IDLE until load/start.
REQ-030 First edge after reset release SHALL process inputs normally per REQ-015.

Verification
REQ-031 WIDTH=8: load preset=3, start, count_en=1 -> out 3,2,1,0; tc one pulse with out=0; done=1; busy low from that cycle.
REQ-032 load 2, auto_reload=1, start, count_en=1 for 8 cycles -> out 2,1,2,1,...; tc pulses every 2 cycles; done stays 0.
REQ-033 load 5, start, count_en toggled 1/0 -> out decrements only on count_en=1 cycles; tc after 5 enabled cycles.
REQ-034 Mid-RUN out=4: assert load(preset=9) and stop same edge -> out=9, IDLE, busy=0, no tc.
REQ-035 load 0, start -> DONE next cycle, tc one pulse, done=1, out=0; second start repeats same.
REQ-036 Mid-RUN out=7: pulse reset low between clk edges -> out=0, busy=0, done=0 immediately; rld=0 after release.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot and auto-reload modes.
// Runs IDLE -> RUN -> DONE. A registered tc pulse marks each terminal count
// and a sticky done flag marks one-shot completion.
module countdown_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] preset,
  input  logic             start,
  input  logic             stop,
  input  logic             count_en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rld, rld_nxt;
  logic [WIDTH-1:0] out_nxt;
  logic             tc_nxt, done_nxt;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rld   <= '0;
      out   <= '0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      rld   <= rld_nxt;
      out   <= out_nxt;
      tc    <= tc_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state and datapath decode; priority is load > stop > start > count.
  always_comb begin
    state_nxt = state;
    rld_nxt   = rld;
    out_nxt   = out;
    tc_nxt    = 1'b0;
    done_nxt  = done;
    if (load) begin
      out_nxt   = preset;
      rld_nxt   = preset;
      state_nxt = IDLE;
      done_nxt  = 1'b0;
    end else if (stop) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
    end else if (start && (state != RUN)) begin
      out_nxt = rld;
      if (rld == '0) begin
        // Zero reload completes immediately rather than entering RUN.
        state_nxt = DONE;
        done_nxt  = 1'b1;
        tc_nxt    = 1'b1;
      end else begin
        state_nxt = RUN;
        done_nxt  = 1'b0;
      end
    end else if ((state == RUN) && count_en) begin
      if (out > WIDTH'(1)) begin
        out_nxt = out - WIDTH'(1);
      end else if (out == WIDTH'(1)) begin
        tc_nxt = 1'b1;
        if (auto_reload) begin
          out_nxt = rld;
        end else begin
          out_nxt   = '0;
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end
      end
    end
  end

  // busy decodes the state register only, so it has no input-to-output path.
  always_comb begin
    busy = (state == RUN);
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with constant
// expectations plus a randomized run against a behavioural model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load, start, stop, count_en, auto_reload;
  logic [7:0] preset;
  logic [7:0] out;
  logic       busy, tc, done;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // model: remaining count, reload value, phase (0 idle, 1 running, 2 finished)
  int m_out, m_rld, m_phase, m_tc, m_done;

  countdown_timer #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .load(load), .preset(preset), .start(start),
    .stop(stop), .count_en(count_en), .auto_reload(auto_reload),
    .out(out), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_out = 0; m_rld = 0; m_phase = 0; m_tc = 0; m_done = 0;
  endtask

  // Applies one clock edge to the model from the rules of the timer.
  task automatic model_edge(input int l, input int p, input int s, input int sp,
                            input int c, input int a);
    m_tc = 0;
    if (l != 0) begin
      m_out = p; m_rld = p; m_phase = 0; m_done = 0;
    end else if (sp != 0) begin
      m_phase = 0; m_done = 0;
    end else if (s != 0 && m_phase != 1) begin
      m_out = m_rld;
      if (m_rld == 0) begin m_phase = 2; m_done = 1; m_tc = 1; end
      else begin m_phase = 1; m_done = 0; end
    end else if (m_phase == 1 && c != 0 && m_out > 0) begin
      m_out = m_out - 1;
      if (m_out == 0) begin
        m_tc = 1;
        if (a != 0) m_out = m_rld;
        else begin m_phase = 2; m_done = 1; end
      end
    end
  endtask

  task automatic step(input logic l, input logic [7:0] p, input logic s,
                      input logic sp, input logic c, input logic a);
    load = l; preset = p; start = s; stop = sp; count_en = c; auto_reload = a;
    @(posedge clk);
    model_edge(int'(l), int'(p), int'(s), int'(sp), int'(c), int'(a));
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load = 0; preset = 0; start = 0; stop = 0; count_en = 0; auto_reload = 0;
    model_reset();
    #1;
    total++;
    if ({out, busy, tc, done} !== 11'd0) $display("FAIL reset: out=%0d busy=%b tc=%b done=%b, want all 0", out, busy, tc, done);
    else passed++;
    @(negedge clk); reset = 1'b1;
    step(0, 0, 0, 0, 1, 0);
    total++;
    if ({out, busy, tc, done} !== 11'd0) $display("FAIL reset_idle: out=%0d busy=%b tc=%b done=%b, want all 0", out, busy, tc, done);
    else passed++;
  endtask

  task automatic test_oneshot();
    int exp_out [4] = '{3, 2, 1, 0};
    step(1, 3, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out !== 8'(exp_out[i]) || busy !== (i < 3) || tc !== (i == 3) || done !== (i == 3))
        $display("FAIL oneshot[%0d]: out=%0d busy=%b tc=%b done=%b, want out=%0d busy=%b tc=%b done=%b",
                 i, out, busy, tc, done, exp_out[i], i < 3, i == 3, i == 3);
      else passed++;
      step(0, 0, 0, 0, 1, 0);
    end
    total++;
    if (tc !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || out !== 8'd0)
      $display("FAIL oneshot_hold: out=%0d busy=%b tc=%b done=%b, want out=0 busy=0 tc=0 done=1", out, busy, tc, done);
    else passed++;
  endtask

  task automatic test_autoreload();
    step(1, 2, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0, 1, 1);
      total++;
      if (out !== ((i % 2 == 1) ? 8'd1 : 8'd2) || tc !== (i % 2 == 0) || done !== 1'b0 || busy !== 1'b1)
        $display("FAIL autoreload[%0d]: out=%0d busy=%b tc=%b done=%b, want out=%0d busy=1 tc=%b done=0",
                 i, out, busy, tc, done, (i % 2 == 1) ? 1 : 2, i % 2 == 0);
      else passed++;
    end
  endtask

  task automatic test_gated();
    int en = 0;
    step(1, 5, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, (i % 2 == 0), 0);
      if (i % 2 == 0) en++;
      total++;
      if (out !== 8'(5 - en) || tc !== (en == 5 && i % 2 == 0) || done !== (en == 5))
        $display("FAIL gated[%0d]: out=%0d tc=%b done=%b, want out=%0d tc=%b done=%b",
                 i, out, tc, done, 5 - en, en == 5 && i % 2 == 0, en == 5);
      else passed++;
    end
  endtask

  task automatic test_load_stop();
    step(1, 6, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    total++;
    if (out !== 8'd4) $display("FAIL load_stop_pre: out=%0d, want 4", out);
    else passed++;
    step(1, 9, 0, 1, 1, 0);
    total++;
    if (out !== 8'd9 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0)
      $display("FAIL load_stop: out=%0d busy=%b tc=%b done=%b, want out=9 busy=0 tc=0 done=0", out, busy, tc, done);
    else passed++;
  endtask

  task automatic test_zero();
    step(1, 0, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      step(0, 0, 1, 0, 1, 0);
      total++;
      if (out !== 8'd0 || busy !== 1'b0 || tc !== 1'b1 || done !== 1'b1)
        $display("FAIL zero_start[%0d]: out=%0d busy=%b tc=%b done=%b, want out=0 busy=0 tc=1 done=1", r, out, busy, tc, done);
      else passed++;
      step(0, 0, 0, 0, 1, 0);
      total++;
      if (tc !== 1'b0 || done !== 1'b1)
        $display("FAIL zero_after[%0d]: tc=%b done=%b, want tc=0 done=1", r, tc, done);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, (i == 1), 0, 1, 1);
      total++;
      if (out !== 8'd1 || tc !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL back_to_back[%0d]: out=%0d busy=%b tc=%b done=%b, want out=1 busy=1 tc=1 done=0", i, out, busy, tc, done);
      else passed++;
    end
    step(0, 0, 0, 1, 1, 1);
    total++;
    if (busy !== 1'b0 || tc !== 1'b0 || out !== 8'd1)
      $display("FAIL stop_hold: out=%0d busy=%b tc=%b, want out=1 busy=0 tc=0", out, busy, tc);
    else passed++;
  endtask

  task automatic test_async_reset();
    step(1, 9, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    total++;
    if (out !== 8'd7 || busy !== 1'b1) $display("FAIL async_pre: out=%0d busy=%b, want out=7 busy=1", out, busy);
    else passed++;
    @(negedge clk); reset = 1'b0; #1;
    total++;
    if ({out, busy, tc, done} !== 11'd0) $display("FAIL async_now: out=%0d busy=%b tc=%b done=%b, want all 0", out, busy, tc, done);
    else passed++;
    @(negedge clk); reset = 1'b1;
    model_reset();
    step(0, 0, 0, 0, 1, 0);
    total++;
    if ({out, busy, tc, done} !== 11'd0) $display("FAIL async_idle: out=%0d busy=%b tc=%b done=%b, want all 0", out, busy, tc, done);
    else passed++;
    step(0, 0, 1, 0, 1, 0);
    total++;
    if (out !== 8'd0 || busy !== 1'b0 || tc !== 1'b1 || done !== 1'b1)
      $display("FAIL async_rld0: out=%0d busy=%b tc=%b done=%b, want out=0 busy=0 tc=1 done=1", out, busy, tc, done);
    else passed++;
  endtask

  task automatic test_random();
    logic l, s, sp, c, a;
    logic [7:0] p;
    for (int i = 0; i < 400; i++) begin
      l  = ($urandom_range(0, 15) == 0);
      sp = ($urandom_range(0, 24) == 0);
      s  = ($urandom_range(0, 7) == 0);
      c  = ($urandom_range(0, 3) != 0);
      a  = $urandom_range(0, 1) == 1;
      p  = 8'($urandom_range(0, 6));
      step(l, p, s, sp, c, a);
      total++;
      if (out !== 8'(m_out) || busy !== (m_phase == 1) || tc !== (m_tc != 0) || done !== (m_done != 0))
        $display("FAIL random[%0d]: out=%0d busy=%b tc=%b done=%b, want out=%0d busy=%b tc=%b done=%b",
                 i, out, busy, tc, done, m_out, m_phase == 1, m_tc != 0, m_done != 0);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_gated();
    test_load_stop();
    test_zero();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
